// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forward-select encodings, register-index width,
// and the per-cycle pipeline condition used by the hazard/forward controller.
package cpu_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  // What the pipeline does on the coming edge, highest priority last.
  typedef enum logic [1:0] {
    COND_NORMAL = 2'd0,
    COND_HAZARD = 2'd1,
    COND_FLUSH  = 2'd2,
    COND_FREEZE = 2'd3
  } cond_e;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_select.sv
// Operand-source comparator for one EX operand. Picks the youngest in-flight
// producer of the register: EX/MEM result beats MEM/WB data beats regfile.
module fwd_select #(
  parameter int REG_W = cpu_pkg::REG_W
) (
  input  logic             use_src,
  input  logic [REG_W-1:0] src,
  input  logic             ex_valid,
  input  logic             ex_regwrite,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_valid,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_rd,
  output logic [1:0]       sel
);
  import cpu_pkg::*;

  logic ex_hit, mem_hit;

  // x0 is hardwired zero, so a producer targeting it never forwards
  assign ex_hit  = use_src & ex_valid  & ex_regwrite  & (ex_rd  != '0) & (ex_rd  == src);
  assign mem_hit = use_src & mem_valid & mem_regwrite & (mem_rd != '0) & (mem_rd == src);

  // EX match is the newer value and wins over MEM
  always_comb begin
    sel = FWD_REGFILE;
    if (ex_hit)       sel = FWD_EXMEM;
    else if (mem_hit) sel = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forward controller for the 5-stage pipeline: shadows destination
// metadata of the instructions in EX and MEM, registers the EX operand
// selects, and raises load-use stall / bubble controls with flush and freeze.
// Only EX and MEM metadata feed any decision; an instruction leaving MEM is
// already visible through the register file, so it is not tracked further.
module hazard_fwd_ctrl #(
  parameter int REG_W = cpu_pkg::REG_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  input  logic             mem_busy,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);
  import cpu_pkg::*;

  localparam int STAGES = 1;          // vld_pipe[0] = EX, vld_pipe[1] = MEM
  localparam int NUM_SRC = 2;         // rs1 -> ForwardA, rs2 -> ForwardB

  logic [STAGES:0]             vld_pipe;
  logic                        ex_valid, mem_valid;
  logic [REG_W-1:0]            ex_rd, mem_rd;
  logic                        ex_regwrite, ex_memread, mem_regwrite;

  logic [NUM_SRC-1:0][REG_W-1:0] src;
  logic [NUM_SRC-1:0]            src_use;
  logic [NUM_SRC-1:0][1:0]       fwd_next;
  logic [1:0]                    fwd_hits;
  logic                          hazard;
  cond_e                         cond;

  assign ex_valid  = vld_pipe[0];
  assign mem_valid = vld_pipe[1];

  assign src     = {id_rs2, id_rs1};
  assign src_use = {id_use_rs2, id_use_rs1};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_sel
    fwd_select #(.REG_W(REG_W)) u_sel (
      .use_src      (src_use[s]),
      .src          (src[s]),
      .ex_valid     (ex_valid),
      .ex_regwrite  (ex_regwrite),
      .ex_rd        (ex_rd),
      .mem_valid    (mem_valid),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .sel          (fwd_next[s])
    );
  end

  assign fwd_hits = 2'(fwd_next[0] != FWD_REGFILE) + 2'(fwd_next[1] != FWD_REGFILE);

  // Load in EX whose result a source in ID needs: the value only exists after MEM
  assign hazard = id_valid & ex_valid & ex_memread & (ex_rd != '0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // Resolve the cycle's condition: freeze > flush > load-use hazard > advance
  always_comb begin
    cond = COND_NORMAL;
    if (mem_busy)    cond = COND_FREEZE;
    else if (flush)  cond = COND_FLUSH;
    else if (hazard) cond = COND_HAZARD;
  end

  // Front-end controls, same-cycle; reset forces them quiet
  always_comb begin
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    bubble_ex  = 1'b0;
    if (!rst) begin
      unique case (cond)
        COND_FREEZE: begin stall_pc = 1'b1; stall_ifid = 1'b1; end
        COND_FLUSH:  bubble_ex = 1'b1;
        COND_HAZARD: begin stall_pc = 1'b1; stall_ifid = 1'b1; bubble_ex = 1'b1; end
        default: ;
      endcase
    end
  end

  // Stage shadow registers, registered forward selects and event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe     <= '0;
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      ForwardA     <= FWD_REGFILE;
      ForwardB     <= FWD_REGFILE;
      stall_cnt    <= '0;
      fwd_cnt      <= '0;
    end else if (cond != COND_FREEZE) begin
      // MEM always takes whatever sat in EX, bubble or not
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      if (cond == COND_NORMAL) begin
        vld_pipe    <= {vld_pipe[STAGES-1:0], id_valid};
        ex_rd       <= id_rd;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
        ForwardA    <= fwd_next[0];
        ForwardB    <= fwd_next[1];
        fwd_cnt     <= fwd_cnt + CNT_W'(fwd_hits);
      end else begin
        // flush or load-use: EX receives a bubble
        vld_pipe    <= {vld_pipe[STAGES-1:0], 1'b0};
        ex_rd       <= '0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ForwardA    <= FWD_REGFILE;
        ForwardB    <= FWD_REGFILE;
        if (cond == COND_HAZARD) stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed instruction sequences with fixed
// expectations, then randomized traffic against an instruction-level model.
module tb_hazard_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic        flush, mem_busy;
  logic [1:0]  ForwardA, ForwardB;
  logic        stall_pc, stall_ifid, bubble_ex;
  logic [31:0] stall_cnt, fwd_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .mem_busy(mem_busy), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_ex(bubble_ex),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  // ---------------- reference model: instructions in flight ----------------
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } ins_t;

  ins_t      m_ex, m_mem;
  bit [1:0]  m_fa, m_fb;
  bit [31:0] m_stall, m_fwd;

  function automatic bit [1:0] m_src(bit u, bit [4:0] s);
    if (u && m_ex.v && m_ex.rw && m_ex.rd != 0 && m_ex.rd == s) return 2'b10;
    if (u && m_mem.v && m_mem.rw && m_mem.rd != 0 && m_mem.rd == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_hazard();
    return id_valid && m_ex.v && m_ex.mr && m_ex.rd != 0 &&
           ((id_use_rs1 && id_rs1 == m_ex.rd) || (id_use_rs2 && id_rs2 == m_ex.rd));
  endfunction

  function automatic bit m_stall_out();
    return !rst && (mem_busy || (!flush && m_hazard()));
  endfunction

  function automatic bit m_bubble_out();
    return !rst && !mem_busy && (flush || m_hazard());
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ex <= '{0, 0, 0, 0}; m_mem <= '{0, 0, 0, 0};
      m_fa <= 0; m_fb <= 0; m_stall <= 0; m_fwd <= 0;
    end else if (!mem_busy) begin
      m_mem <= m_ex;
      if (flush || m_hazard()) begin
        m_ex <= '{0, 0, 0, 0};
        m_fa <= 0; m_fb <= 0;
        if (!flush) m_stall <= m_stall + 1;
      end else begin
        m_ex <= '{id_valid, id_rd, id_regwrite, id_memread};
        m_fa <= m_src(id_use_rs1, id_rs1);
        m_fb <= m_src(id_use_rs2, id_rs2);
        m_fwd <= m_fwd + 32'(m_src(id_use_rs1, id_rs1) != 0) + 32'(m_src(id_use_rs2, id_rs2) != 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2, input bit u1,
                        input bit u2, input int rd, input bit rw, input bit mr);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = 5'(rd);
    id_regwrite = rw; id_memread = mr;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; mem_busy = 0; nop();
    tick(); tick();
    rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; flush = 0; mem_busy = 1; set_id(1, 5, 5, 1, 1, 5, 1, 1);
    tick(); tick();
    checks++;
    if ({ForwardA, ForwardB, stall_pc, stall_ifid, bubble_ex} !== 7'b0 || stall_cnt !== 0 || fwd_cnt !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got fa=%b fb=%b st=%b%b bub=%b sc=%0d fc=%0d want all zero",
               ForwardA, ForwardB, stall_pc, stall_ifid, bubble_ex, stall_cnt, fwd_cnt);
    end
    rst = 0; mem_busy = 0; nop(); #1;
    checks++;
    if ({stall_pc, bubble_ex} !== 2'b00) begin
      errors++; $display("FAIL post_reset_stall: got st=%b bub=%b want 0 0", stall_pc, bubble_ex);
    end
  endtask

  task automatic test_fwd_exmem();
    do_reset();
    set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();          // ADD x5,x1,x2
    set_id(1, 5, 1, 1, 1, 6, 1, 0); #1;              // SUB x6,x5,x1
    checks++;
    if (stall_pc !== 1'b0) begin errors++; $display("FAIL exmem_nostall: got %b want 0", stall_pc); end
    tick(); nop();
    checks++;
    if (ForwardA !== 2'b10 || ForwardB !== 2'b00 || fwd_cnt !== 1) begin
      errors++; $display("FAIL exmem_fwd: got fa=%b fb=%b fc=%0d want 10 00 1", ForwardA, ForwardB, fwd_cnt);
    end
  endtask

  task automatic test_fwd_memwb();
    do_reset();
    set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();          // ADD x5
    nop(); tick();                                   // NOP
    set_id(1, 1, 5, 1, 1, 7, 1, 0); tick();          // OR x7,x1,x5
    nop();
    checks++;
    if (ForwardA !== 2'b00 || ForwardB !== 2'b01) begin
      errors++; $display("FAIL memwb_fwd: got fa=%b fb=%b want 00 01", ForwardA, ForwardB);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 1, 0, 1, 0, 5, 1, 1); tick();          // LW x5,0(x1)
    set_id(1, 5, 5, 1, 1, 6, 1, 0); #1;              // ADD x6,x5,x5
    checks++;
    if ({stall_pc, stall_ifid, bubble_ex} !== 3'b111) begin
      errors++; $display("FAIL lu_stall: got %b%b%b want 111", stall_pc, stall_ifid, bubble_ex);
    end
    tick();                                          // ID held during retry
    checks++;
    if (stall_cnt !== 1 || {stall_pc, stall_ifid, bubble_ex} !== 3'b000 || ForwardA !== 2'b00) begin
      errors++; $display("FAIL lu_retry: got sc=%0d ctl=%b%b%b fa=%b want 1 000 00",
                         stall_cnt, stall_pc, stall_ifid, bubble_ex, ForwardA);
    end
    tick(); nop();
    checks++;
    if (ForwardA !== 2'b01 || ForwardB !== 2'b01 || stall_cnt !== 1 || fwd_cnt !== 2) begin
      errors++; $display("FAIL lu_fwd: got fa=%b fb=%b sc=%0d fc=%0d want 01 01 1 2",
                         ForwardA, ForwardB, stall_cnt, fwd_cnt);
    end
  endtask

  task automatic test_x0_and_unused();
    do_reset();
    set_id(1, 1, 2, 1, 1, 0, 1, 1); tick();          // LW x0 (writes x0)
    set_id(1, 0, 0, 1, 1, 5, 1, 0); #1;              // ADD x5,x0,x0
    checks++;
    if (stall_pc !== 1'b0 || bubble_ex !== 1'b0) begin
      errors++; $display("FAIL x0_nostall: got st=%b bub=%b want 0 0", stall_pc, bubble_ex);
    end
    tick();
    checks++;
    if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
      errors++; $display("FAIL x0_nofwd: got fa=%b fb=%b want 00 00", ForwardA, ForwardB);
    end
    set_id(1, 3, 5, 1, 0, 8, 1, 0); tick(); nop();   // rs2=x5 matches but unused
    checks++;
    if (ForwardA !== 2'b00 || ForwardB !== 2'b00 || fwd_cnt !== 0) begin
      errors++; $display("FAIL unused_nofwd: got fa=%b fb=%b fc=%0d want 00 00 0", ForwardA, ForwardB, fwd_cnt);
    end
  endtask

  task automatic test_flush_over_hazard();
    do_reset();
    set_id(1, 1, 0, 1, 0, 5, 1, 1); tick();          // LW x5
    set_id(1, 5, 2, 1, 1, 6, 1, 0); flush = 1; #1;
    checks++;
    if (stall_pc !== 1'b0 || stall_ifid !== 1'b0 || bubble_ex !== 1'b1) begin
      errors++; $display("FAIL flush_ctl: got st=%b%b bub=%b want 00 1", stall_pc, stall_ifid, bubble_ex);
    end
    tick(); flush = 0; nop();
    checks++;
    if (stall_cnt !== 0 || ForwardA !== 2'b00) begin
      errors++; $display("FAIL flush_cnt: got sc=%0d fa=%b want 0 00", stall_cnt, ForwardA);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    set_id(1, 1, 0, 1, 0, 5, 1, 1); tick();          // LW x5
    set_id(1, 5, 2, 1, 1, 6, 1, 0); mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stall_pc !== 1'b1 || stall_ifid !== 1'b1 || bubble_ex !== 1'b0) begin
        errors++; $display("FAIL freeze_ctl[%0d]: got st=%b%b bub=%b want 11 0", i, stall_pc, stall_ifid, bubble_ex);
      end
      tick();
      checks++;
      if (stall_cnt !== 0 || fwd_cnt !== 0 || ForwardA !== 2'b00) begin
        errors++; $display("FAIL freeze_hold[%0d]: got sc=%0d fc=%0d fa=%b want 0 0 00", i, stall_cnt, fwd_cnt, ForwardA);
      end
    end
    mem_busy = 0; #1;
    checks++;
    if ({stall_pc, stall_ifid, bubble_ex} !== 3'b111) begin
      errors++; $display("FAIL freeze_release: got %b%b%b want 111", stall_pc, stall_ifid, bubble_ex);
    end
    tick(); tick(); nop();
    checks++;
    if (stall_cnt !== 1 || ForwardA !== 2'b01 || ForwardB !== 2'b00) begin
      errors++; $display("FAIL freeze_after: got sc=%0d fa=%b fb=%b want 1 01 00", stall_cnt, ForwardA, ForwardB);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1, 1, 0, 1, 0, 5, 1, 1); tick();          // LW x5
    set_id(1, 5, 0, 1, 0, 6, 1, 1); tick();          // LW x6,0(x5): stall
    tick();                                          // retry, LW x6 enters EX
    set_id(1, 6, 3, 1, 1, 7, 1, 0); #1;              // ADD x7,x6,x3: stall again
    checks++;
    if ({stall_pc, bubble_ex} !== 2'b11 || ForwardA !== 2'b01) begin
      errors++; $display("FAIL b2b_second: got st=%b bub=%b fa=%b want 1 1 01", stall_pc, bubble_ex, ForwardA);
    end
    tick(); tick(); nop();
    checks++;
    if (stall_cnt !== 2 || ForwardA !== 2'b01 || fwd_cnt !== 2) begin
      errors++; $display("FAIL b2b_cnt: got sc=%0d fa=%b fc=%0d want 2 01 2", stall_cnt, ForwardA, fwd_cnt);
    end
  endtask

  task automatic test_rst_mid_freeze();
    do_reset();
    set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();
    set_id(1, 5, 1, 1, 1, 6, 1, 0); tick();          // ForwardA now 10
    mem_busy = 1; tick();
    rst = 1; #1;
    checks++;
    if ({stall_pc, stall_ifid, bubble_ex} !== 3'b000) begin
      errors++; $display("FAIL rst_freeze_ctl: got %b%b%b want 000", stall_pc, stall_ifid, bubble_ex);
    end
    tick();
    checks++;
    if (ForwardA !== 2'b00 || ForwardB !== 2'b00 || fwd_cnt !== 0 || stall_cnt !== 0) begin
      errors++; $display("FAIL rst_freeze_regs: got fa=%b fb=%b fc=%0d sc=%0d want 00 00 0 0",
                         ForwardA, ForwardB, fwd_cnt, stall_cnt);
    end
    rst = 0; mem_busy = 0; nop();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_id($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      mem_busy = ($urandom_range(0, 6) == 0);
      rst      = ($urandom_range(0, 49) == 0);
      #1;
      checks++;
      if (stall_pc !== m_stall_out() || stall_ifid !== m_stall_out() || bubble_ex !== m_bubble_out()) begin
        errors++; $display("FAIL rand_ctl cycle %0d: got %b%b%b want %b%b%b", c,
                           stall_pc, stall_ifid, bubble_ex, m_stall_out(), m_stall_out(), m_bubble_out());
      end
      checks++;
      if (ForwardA !== m_fa || ForwardB !== m_fb || stall_cnt !== m_stall || fwd_cnt !== m_fwd) begin
        errors++; $display("FAIL rand_regs cycle %0d: got fa=%b fb=%b sc=%0d fc=%0d want %b %b %0d %0d", c,
                           ForwardA, ForwardB, stall_cnt, fwd_cnt, m_fa, m_fb, m_stall, m_fwd);
      end
      tick();
    end
    rst = 0; mem_busy = 0; flush = 0; nop();
  endtask

  initial begin
    rst = 1; flush = 0; mem_busy = 0; nop();
    test_reset();
    test_fwd_exmem();
    test_fwd_memwb();
    test_load_use();
    test_x0_and_unused();
    test_flush_over_hazard();
    test_freeze();
    test_back_to_back();
    test_rst_mid_freeze();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
